// File: rtl/mmio_host_seq_if.sv
// Byte-wide MMIO bus between the host sequencer (master) and the coprocessor
// register shadow (slave); rdata is combinational from the slave during cs&&rd.
interface mmio_host_seq_if;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output cs, rd, wr, addr, wdata, input rdata);
    modport slave  (input cs, rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_host_seq.sv
// Bus-initiator sequencer: turns one compute request into the MMIO write sequence,
// polls STATUS.valid with a timeout, reads G and returns it on a ready/valid port.
module mmio_host_seq #(
    parameter int START_GAP = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [7:0]      req_T,
    input  logic [7:0]      req_dT,
    input  logic            req_reg_mode,
    input  logic            req_dt_mode,
    input  logic            req_init,
    input  logic            req_load_thr,
    output logic [4:0]      thr_idx,
    input  logic [7:0]      thr_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [7:0]      rsp_G,
    output logic            rsp_timeout,
    mmio_host_seq_if.master bus
);
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] GAP_END  = CW'(START_GAP + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [4:0]    THR_LAST = 5'd23;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_THR   = 4'd2,
        S_MODE  = 4'd3,
        S_WT    = 4'd4,
        S_WDT   = 4'd5,
        S_START = 4'd6,
        S_GAP   = 4'd7,
        S_POLL  = 4'd8,
        S_READG = 4'd9,
        S_RESP  = 4'd10
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [7:0]    t_r;
    logic [7:0]    dt_r;
    logic          reg_mode_r;
    logic          dt_mode_r;
    logic          load_thr_r;
    logic [4:0]    thr_idx_r;
    logic [4:0]    thr_idx_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          cs_r;
    logic          rd_r;
    logic          wr_r;
    logic [7:0]    addr_r;
    logic [7:0]    wdata_r;
    logic          cs_s;
    logic          rd_s;
    logic          wr_s;
    logic [7:0]    addr_s;
    logic [7:0]    wdata_s;
    logic          ready_r;
    logic          rsp_valid_r;
    logic          rsp_timeout_r;
    logic [7:0]    rsp_g_r;
    logic          req_fire_s;
    logic          f_reg_s;
    logic          f_dtm_s;

    // Mode bits are needed by the very first write, which is built in the accept cycle.
    assign req_fire_s = req_valid && ready_r;
    assign f_reg_s    = req_fire_s ? req_reg_mode : reg_mode_r;
    assign f_dtm_s    = req_fire_s ? req_dt_mode  : dt_mode_r;

    assign req_ready   = ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_G       = rsp_g_r;
    assign rsp_timeout = rsp_timeout_r;
    assign thr_idx     = thr_idx_r;
    assign bus.cs      = cs_r;
    assign bus.rd      = rd_r;
    assign bus.wr      = wr_r;
    assign bus.addr    = addr_r;
    assign bus.wdata   = wdata_r;

    // Next-state decode.
    // thr_idx runs one ahead of the bus so thr_data can be registered into wdata;
    // it wraps to 0 while the last threshold write is on the bus.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_fire_s) begin
                    if (req_init) begin
                        next_state_s = S_INIT;
                    end else if (req_load_thr) begin
                        next_state_s = S_THR;
                    end else begin
                        next_state_s = S_MODE;
                    end
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_INIT:  next_state_s = load_thr_r ? S_THR : S_MODE;
            S_THR:   next_state_s = (thr_idx_r == 5'd0) ? S_MODE : S_THR;
            S_MODE:  next_state_s = S_WT;
            S_WT:    next_state_s = dt_mode_r ? S_START : S_WDT;
            S_WDT:   next_state_s = S_START;
            S_START: next_state_s = S_GAP;
            S_GAP:   next_state_s = (cnt_r == GAP_END) ? S_POLL : S_GAP;
            S_POLL: begin
                if (bus.rdata[0]) begin
                    next_state_s = S_READG;
                end else if (cnt_r >= CNT_MAX) begin
                    next_state_s = S_RESP;
                end else begin
                    next_state_s = S_POLL;
                end
            end
            S_READG: next_state_s = S_RESP;
            S_RESP:  next_state_s = rsp_ready ? S_IDLE : S_RESP;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Bus access for the state being entered, so strobes leave a register.
    always_comb begin
        cs_s      = 1'b0;
        rd_s      = 1'b0;
        wr_s      = 1'b0;
        addr_s    = 8'h00;
        wdata_s   = 8'h00;
        thr_idx_s = 5'd0;
        case (next_state_s)
            S_INIT: begin
                cs_s    = 1'b1;
                wr_s    = 1'b1;
                addr_s  = 8'h01;
                wdata_s = {4'b0000, 1'b1, f_dtm_s, f_reg_s, 1'b0};
            end
            S_THR: begin
                cs_s      = 1'b1;
                wr_s      = 1'b1;
                addr_s    = 8'h10 + {3'b000, thr_idx_r};
                wdata_s   = thr_data;
                thr_idx_s = (thr_idx_r == THR_LAST) ? 5'd0 : (thr_idx_r + 5'd1);
            end
            S_MODE: begin
                cs_s    = 1'b1;
                wr_s    = 1'b1;
                addr_s  = 8'h01;
                wdata_s = {5'b00000, f_dtm_s, f_reg_s, 1'b0};
            end
            S_WT: begin
                cs_s    = 1'b1;
                wr_s    = 1'b1;
                addr_s  = 8'h02;
                wdata_s = t_r;
            end
            S_WDT: begin
                cs_s    = 1'b1;
                wr_s    = 1'b1;
                addr_s  = 8'h03;
                wdata_s = dt_r;
            end
            S_START: begin
                cs_s    = 1'b1;
                wr_s    = 1'b1;
                addr_s  = 8'h01;
                wdata_s = {5'b00000, dt_mode_r, reg_mode_r, 1'b1};
            end
            S_POLL: begin
                cs_s   = 1'b1;
                rd_s   = 1'b1;
                addr_s = 8'h00;
            end
            S_READG: begin
                cs_s   = 1'b1;
                rd_s   = 1'b1;
                addr_s = 8'h04;
            end
            default: cs_s = 1'b0;
        endcase
    end

    // Cycle counter from the START write; saturates at TIMEOUT.
    always_comb begin
        if (next_state_s == S_START) begin
            cnt_s = CNT_ONE;
        end else if (((state_r == S_START) || (state_r == S_GAP) || (state_r == S_POLL))
                     && (cnt_r != CNT_MAX)) begin
            cnt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State, bus and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            cs_r        <= 1'b0;
            rd_r        <= 1'b0;
            wr_r        <= 1'b0;
            addr_r      <= 8'h00;
            wdata_r     <= 8'h00;
            thr_idx_r   <= 5'd0;
            cnt_r       <= '0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cs_r        <= cs_s;
            rd_r        <= rd_s;
            wr_r        <= wr_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            thr_idx_r   <= thr_idx_s;
            cnt_r       <= cnt_s;
            ready_r     <= (next_state_s == S_IDLE);
            rsp_valid_r <= (next_state_s == S_RESP);
        end
    end

    // Request fields captured on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_r        <= 8'h00;
            dt_r       <= 8'h00;
            reg_mode_r <= 1'b0;
            dt_mode_r  <= 1'b0;
            load_thr_r <= 1'b0;
        end else if (req_fire_s) begin
            t_r        <= req_T;
            dt_r       <= req_dT;
            reg_mode_r <= req_reg_mode;
            dt_mode_r  <= req_dt_mode;
            load_thr_r <= req_load_thr;
        end else begin
            t_r        <= t_r;
            dt_r       <= dt_r;
            reg_mode_r <= reg_mode_r;
            dt_mode_r  <= dt_mode_r;
            load_thr_r <= load_thr_r;
        end
    end

    // Result capture: G from the 0x04 read, or zero with the timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_g_r       <= 8'h00;
            rsp_timeout_r <= 1'b0;
        end else if (state_r == S_READG) begin
            rsp_g_r       <= bus.rdata;
            rsp_timeout_r <= 1'b0;
        end else if ((state_r == S_POLL) && (next_state_s == S_RESP)) begin
            rsp_g_r       <= 8'h00;
            rsp_timeout_r <= 1'b1;
        end else begin
            rsp_g_r       <= rsp_g_r;
            rsp_timeout_r <= rsp_timeout_r;
        end
    end
endmodule

// File: tb/tb_mmio_host_seq.sv
// Self-checking bench for mmio_host_seq: stub register shadow, table vectors,
// randomized requests against a latency/bus-trace reference model.
module tb_mmio_host_seq;
    localparam int GAP = 2;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_T;
    logic [7:0] req_dT;
    logic       req_reg_mode;
    logic       req_dt_mode;
    logic       req_init;
    logic       req_load_thr;
    logic [4:0] thr_idx;
    logic [7:0] thr_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_G;
    logic       rsp_timeout;

    mmio_host_seq_if bus ();

    mmio_host_seq #(.START_GAP(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_T(req_T), .req_dT(req_dT),
        .req_reg_mode(req_reg_mode), .req_dt_mode(req_dt_mode),
        .req_init(req_init), .req_load_thr(req_load_thr),
        .thr_idx(thr_idx), .thr_data(thr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_G(rsp_G), .rsp_timeout(rsp_timeout),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave stub: STATUS.valid rises stub_delay cycles after the START write.
    int         stub_delay = 1;
    logic [7:0] stub_g     = 8'h00;
    logic       started    = 1'b0;
    int         start_cyc  = 0;
    logic       stub_valid;
    assign thr_data = 8'(thr_idx) * 8'd3;

    always_comb begin
        stub_valid = started && (cyc >= start_cyc + stub_delay);
        if (bus.cs && bus.rd && (bus.addr == 8'h00)) bus.rdata = {7'b0000000, stub_valid};
        else if (bus.cs && bus.rd && (bus.addr == 8'h04)) bus.rdata = stub_g;
        else bus.rdata = 8'h00;
    end

    logic [15:0] wr_log[$];
    logic [7:0]  thr_mem[24];
    int          rd_cnt = 0;
    int          rdg_cnt = 0;
    int          thr_wr_cnt = 0;
    int          both_strobes = 0;

    always @(negedge clk) begin
        if (bus.rd && bus.wr) both_strobes++;
        if (bus.cs && bus.wr) begin
            wr_log.push_back({bus.addr, bus.wdata});
            if (bus.addr == 8'h01) begin
                started = bus.wdata[0];
                if (bus.wdata[0]) start_cyc = cyc;
            end
            if ((bus.addr >= 8'h10) && (bus.addr <= 8'h27)) begin
                thr_mem[5'(bus.addr - 8'h10)] = bus.wdata;
                thr_wr_cnt++;
            end
        end
        if (bus.cs && bus.rd) begin
            rd_cnt++;
            if (bus.addr == 8'h04) rdg_cnt++;
        end
    end

    typedef struct {
        logic [7:0] t;
        logic [7:0] dt;
        logic       regm;
        logic       dtm;
        logic       init;
        logic       thr;
        int         delay;
        logic [7:0] g;
        logic [7:0] exp_g;
        logic       exp_to;
        int         exp_lat;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Polls needed: valid is seen on the first poll at or after it rises.
    function automatic int n_polls(input vec_t v);
        return (v.delay - GAP > 1) ? (v.delay - GAP) : 1;
    endfunction

    // Latency counted in cycles inclusive of the accept cycle.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   n;
        int   s;
        r = v;
        n = n_polls(v);
        s = 4 + int'(v.init) + 24 * int'(v.thr) - int'(v.dtm);
        if (GAP + n > TMO - 1) begin
            r.exp_to  = 1'b1;
            r.exp_g   = 8'h00;
            r.exp_lat = s + TMO + 1;
        end else begin
            r.exp_to  = 1'b0;
            r.exp_g   = v.g;
            r.exp_lat = 7 + GAP + n + int'(v.init) + 24 * int'(v.thr) - int'(v.dtm);
        end
        return r;
    endfunction

    function automatic int exp_reads(input vec_t v);
        vec_t m;
        m = model(v);
        return m.exp_to ? (TMO - 1 - GAP) : (n_polls(v) + 1);
    endfunction

    task automatic drive_req(input vec_t v, input string tag);
        stub_delay = v.delay;
        stub_g     = v.g;
        @(negedge clk);
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
        check({tag, "_req_ready"}, int'(req_ready), 1);
        req_T        = v.t;
        req_dT       = v.dt;
        req_reg_mode = v.regm;
        req_dt_mode  = v.dtm;
        req_init     = v.init;
        req_load_thr = v.thr;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int bp, input string tag);
        int          base;
        int          rd0;
        int          rdg0;
        int          lat;
        int          mism;
        bit          got;
        logic [7:0]  g_hold;
        logic [15:0] exq[$];
        base = wr_log.size();
        rd0  = rd_cnt;
        rdg0 = rdg_cnt;
        drive_req(v, tag);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 200 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                lat = i + 1;
            end
        end
        check({tag, "_lat"}, lat, v.exp_lat);
        check({tag, "_G"}, int'(rsp_G), int'(v.exp_g));
        check({tag, "_timeout"}, int'(rsp_timeout), int'(v.exp_to));
        g_hold = rsp_G;
        // A competing request is held up while the response is stalled.
        if (bp > 0) begin
            req_T     = 8'h5C;
            req_valid = 1'b1;
        end
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check({tag, "_bp_valid"}, int'(rsp_valid), 1);
            check({tag, "_bp_G"}, int'(rsp_G), int'(g_hold));
            check({tag, "_bp_req_ready"}, int'(req_ready), 0);
            check({tag, "_bp_bus_idle"}, int'(bus.cs), 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, int'(rsp_valid), 0);
        check({tag, "_ready_back"}, int'(req_ready), 1);
        if (v.init) exq.push_back({8'h01, 4'b0000, 1'b1, v.dtm, v.regm, 1'b0});
        if (v.thr) for (int i = 0; i < 24; i++) exq.push_back({8'h10 + 8'(i), 8'(i * 3)});
        exq.push_back({8'h01, 5'b00000, v.dtm, v.regm, 1'b0});
        exq.push_back({8'h02, v.t});
        if (!v.dtm) exq.push_back({8'h03, v.dt});
        exq.push_back({8'h01, 5'b00000, v.dtm, v.regm, 1'b1});
        check({tag, "_n_writes"}, wr_log.size() - base, exq.size());
        mism = 0;
        for (int i = 0; i < exq.size(); i++) begin
            if ((base + i >= wr_log.size()) || (wr_log[base + i] != exq[i])) mism++;
        end
        check({tag, "_write_trace"}, mism, 0);
        check({tag, "_n_reads"}, rd_cnt - rd0, exp_reads(v));
        check({tag, "_n_readG"}, rdg_cnt - rdg0, v.exp_to ? 0 : 1);
        if (v.thr) begin
            mism = 0;
            for (int i = 0; i < 24; i++) if (thr_mem[i] != 8'(i * 3)) mism++;
            check({tag, "_thr_mem"}, mism, 0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   t0;
        int   base;
        int   rd0;
        bit   got;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_T        = 8'h00;
        req_dT       = 8'h00;
        req_reg_mode = 1'b0;
        req_dt_mode  = 1'b0;
        req_init     = 1'b0;
        req_load_thr = 1'b0;
        rsp_ready    = 1'b0;

        //          T      dT     reg   dt    init  thr   D    G      expG   expTo lat
        tbl[0] = '{8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0,   3, 8'h37, 8'h37, 1'b0, 10};
        tbl[1] = '{8'h80, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0,   3, 8'h5A, 8'h5A, 1'b0,  9};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1,   5, 8'hC3, 8'hC3, 1'b0, 37};
        tbl[3] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 255, 8'hAA, 8'h00, 1'b1, 21};
        tbl[4] = '{8'h11, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 200, 8'h05, 8'h00, 1'b1, 21};
        tbl[5] = '{8'hC0, 8'h3F, 1'b0, 1'b1, 1'b0, 1'b0,  15, 8'h81, 8'h81, 1'b0, 21};
        tbl[6] = '{8'h01, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0,  16, 8'h99, 8'h00, 1'b1, 21};
        tbl[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0,   1, 8'hFF, 8'hFF, 1'b0, 11};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", int'(req_ready), 1);
        check("reset_rsp_valid", int'(rsp_valid), 0);
        check("reset_rsp_G", int'(rsp_G), 0);
        check("reset_bus", int'({bus.cs, bus.rd, bus.wr, bus.addr, bus.wdata}), 0);
        check("reset_thr_idx", int'(thr_idx), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", int'(req_ready), 1);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], (i == 1) ? 10 : 0, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            v.t     = 8'($urandom);
            v.dt    = 8'($urandom);
            v.regm  = 1'($urandom);
            v.dtm   = 1'($urandom);
            v.init  = 1'($urandom);
            v.thr   = ($urandom_range(0, 3) == 0);
            v.delay = int'($urandom_range(1, 18));
            v.g     = 8'($urandom);
            run_vec(model(v), 0, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of the threshold load.
        v       = tbl[0];
        v.thr   = 1'b1;
        t0      = thr_wr_cnt;
        drive_req(v, "rst_mid");
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #2;
            if (thr_idx == 5'd10) got = 1'b1;
        end
        check("rst_mid_reach_idx10", int'(got), 1);
        check("rst_mid_thr_writes", thr_wr_cnt - t0, 10);
        rst_n = 1'b0;
        #1;
        check("rst_mid_bus", int'({bus.cs, bus.rd, bus.wr, bus.addr, bus.wdata}), 0);
        check("rst_mid_thr_idx", int'(thr_idx), 0);
        check("rst_mid_rsp", int'({rsp_valid, rsp_timeout, rsp_G}), 0);
        check("rst_mid_req_ready", int'(req_ready), 1);
        base = wr_log.size();
        rd0  = rd_cnt;
        repeat (3) @(negedge clk);
        check("rst_mid_no_bus_cycles", (wr_log.size() - base) + (rd_cnt - rd0), 0);
        rst_n = 1'b1;
        run_vec(tbl[0], 0, "post_rst");

        check("rd_wr_exclusive", both_strobes, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_host_seq.md
# mmio_host_seq

Bus-initiator sequencer that drives the 8-bit MMIO bus of the fuzzy coprocessor register shadow. It turns one request (T, dT, mode bits, optional INIT and threshold reload) into the write sequence, polls STATUS.valid, reads G, and returns the result on a ready/valid response port. It sits between a host-side controller (or test harness) and the coprocessor MMIO slave, replacing software bit-banging of the bus.

## Interface
- START_GAP, 2: idle cycles after the START write before the first STATUS poll (>=1)
- TIMEOUT, 1024: max cycles from the START write cycle to valid=1 before abort (>=START_GAP+2)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, accepts request
- req_T  in  8  signed temperature, Q7.0
- req_dT  in  8  signed external dT, Q7.0 (used only when req_dt_mode=0)
- req_reg_mode  in  1  CTRL[1]
- req_dt_mode  in  1  CTRL[2]
- req_init  in  1  issue INIT pulse before computing
- req_load_thr  in  1  reload all 24 thresholds before computing
- thr_idx  out  5  threshold index 0..23 being written
- thr_data  in  8  threshold byte for thr_idx (combinational source, same cycle)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_G  out  8  G read from 0x04 (0 on timeout)
- rsp_timeout  out  1  valid never observed within TIMEOUT
- cs, rd, wr  out  1  MMIO strobes
- addr  out  8  MMIO address
- wdata  out  8  MMIO write data
- rdata  in  8  MMIO read data (combinational from slave when cs&&rd)

## Operation
- All bus outputs registered. One bus access per cycle: write = cs=wr=1 for one cycle; read = cs=rd=1 for one cycle, rdata sampled at the closing edge. rd and wr never both 1. Idle: cs=rd=wr=0, addr=wdata=0.
- States: IDLE, INIT, THR, MODE, WT, WDT, START, GAP, POLL, READG, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready latch all req_* fields; next state INIT if req_init, else THR if req_load_thr, else MODE.
- INIT: write 0x01 = {4'b0, 1, dt, reg, 0}. Next THR if load_thr, else MODE.
- THR: 24 consecutive writes, addr=0x10+thr_idx, wdata=thr_data, thr_idx 0..23; after idx 23 go MODE. thr_idx=0 outside THR.
- MODE: write 0x01 = {5'b0, dt, reg, 0} (no START) so dt_mode is applied before the dT write.
- WT: write 0x02 = T. Next WDT if dt_mode=0, else START (dT write skipped; slave ignores it anyway).
- WDT: write 0x03 = dT.
- START: write 0x01 = {5'b0, dt, reg, 1}. Timeout counter cleared to 1 in this cycle, increments every subsequent cycle.
- GAP: START_GAP idle cycles.
- POLL: read 0x00 every cycle. rdata[0]=1 -> READG. Counter reaching TIMEOUT before that -> RESP with rsp_timeout=1, rsp_G=0.
- READG: read 0x04; latch rdata into rsp_G, rsp_timeout=0; -> RESP.
- RESP: rsp_valid=1, rsp_G/rsp_timeout stable until rsp_ready; on handshake -> IDLE. req_ready=0 in every state but IDLE.
- Counter width = $clog2(TIMEOUT+1); saturates, never wraps.

## Timing
- Reset (async, any state): state IDLE, req_ready=1 after reset release, rsp_valid=0, rsp_G=0, rsp_timeout=0, cs=rd=wr=0, addr=wdata=0, thr_idx=0, counter=0. Reset mid-sequence aborts with no further bus cycles; a partially loaded threshold set is left in the slave.
- Accept at edge k: MODE write is cycle k+1. Minimal path (no init/thr, dt_mode=0): MODE k+1, WT k+2, WDT k+3, START k+4, GAP k+5..k+4+START_GAP, first POLL k+5+START_GAP.
- If valid read on poll n (n>=1), READG is next cycle, rsp_valid rises one cycle later: total from accept = 7+START_GAP+n cycles (dt_mode=0).
- INIT adds 1 cycle, THR adds 24, dt_mode=1 removes 1.
- rsp_valid held across rsp_ready=0 indefinitely; no new request accepted meanwhile.
- Timeout path: rsp_valid rises the cycle after counter reaches TIMEOUT.

## Test plan
- Basic: reg=1, dt=0, T=0x20, dT=0xF0, slave core stub raises valid 3 cycles after START, G=0x37 -> bus writes 0x01=0x02, 0x02=0x20, 0x03=0xF0, 0x01=0x03; rsp_G=0x37, rsp_timeout=0, latency matches formula.
- dt_mode=1, T=0x80 -> no 0x03 write; CTRL bytes 0x06 then 0x07; rsp returned.
- req_init=1, req_load_thr=1, thr_data=idx*3 -> 0x01=0x08|modes first, then 24 writes 0x10..0x27 with data 0..69 step 3, slave threshold outputs match.
- Stub never sets valid, TIMEOUT=16 -> rsp_timeout=1, rsp_G=0 exactly at predicted cycle; no 0x04 read.
- Back-pressure: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_G stable, req_ready=0; second request accepted only after handshake.
- rst_n asserted during THR idx 10 -> all outputs reset same cycle; fresh request completes normally.
